// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline control block.
//   - STOP / NO_STOP      : per-stage stall bit values
//   - STALL_* encodings   : stall vectors, bit [0]=PC ... [5]=WB
//   - mc_state_e          : multi-cycle sequencer states
//   - ZERO_WORD           : 32-bit zero
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Each encoding holds every stage up to and including the requesting one;
  // the first 0 above the run of 1s is where a NOP bubble gets inserted.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/pipe_mc_counter.sv
// pipe_mc_counter: IDLE/BUSY sequencer for multi-cycle EX operations.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   mc_start   in   EX starts a multi-cycle op (ignored while busy)
//   mc_cycles  in   total EX occupancy in cycles, sampled with mc_start
//   abort      in   forces IDLE / count 0 on the next edge (flush)
//   mc_stall   out  combinational EX-level stall request
//   mc_busy    out  registered, 1 while in BUSY
module pipe_mc_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_cycles,
  input  logic                abort,
  output logic                mc_stall,
  output logic                mc_busy
);

  mc_state_e           state_reg, state_next;
  logic [MC_CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= MC_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mc_stall   = NO_STOP;
    case (state_reg)
      MC_IDLE: begin
        // The start cycle itself is the first of the N stall cycles,
        // so BUSY only has N-1 left to cover.
        if (mc_start && (mc_cycles != '0)) begin
          mc_stall = STOP;
          if (mc_cycles != MC_CNT_W'(1)) begin
            state_next = MC_BUSY;
            cnt_next   = mc_cycles - MC_CNT_W'(1);
          end
        end
      end
      MC_BUSY: begin
        mc_stall = STOP;
        if (cnt_reg == MC_CNT_W'(1)) begin
          state_next = MC_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - MC_CNT_W'(1);
        end
      end
      default: begin
        state_next = MC_IDLE;
        cnt_next   = '0;
      end
    endcase
    if (abort) begin
      state_next = MC_IDLE;
      cnt_next   = '0;
    end
  end

  assign mc_busy = (state_reg == MC_BUSY);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
// Merges IF/ID/EX/MEM stall requests and the multi-cycle EX sequencer into a
// 6-bit stall vector ([0]=PC .. [5]=WB), and registers flush requests into a
// one-cycle flush pulse with a redirect PC.
// Ports:
//   clk, rst (async active-low)
//   stallreq_if/id/ex/mem  stage stall requests
//   mc_start, mc_cycles    multi-cycle EX op start and length
//   flush_req, flush_pc    redirect request and target
//   stall                  combinational stall vector
//   flush, new_pc          registered flush pulse and redirect PC
//   mc_busy                registered multi-cycle busy flag
//   stall_cycles           stall[0] cycle counter; present only when the
//                          macro PIPE_PERF_CNT_EN is defined, else 0
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6,
  parameter int PC_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_cycles,
  input  logic                flush_req,
  input  logic [PC_W-1:0]     flush_pc,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [PC_W-1:0]     new_pc,
  output logic                mc_busy,
  output logic [31:0]         stall_cycles
);

  logic            mc_stall;
  logic            flush_reg;
  logic [PC_W-1:0] new_pc_reg;

  pipe_mc_counter #(
    .MC_CNT_W(MC_CNT_W)
  ) u_mc_counter (
    .clk      (clk),
    .rst      (rst),
    .mc_start (mc_start),
    .mc_cycles(mc_cycles),
    .abort    (flush_req),
    .mc_stall (mc_stall),
    .mc_busy  (mc_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_reg  <= 1'b0;
      new_pc_reg <= '0;
    end else begin
      flush_reg <= flush_req;
      if (flush_req) begin
        new_pc_reg <= flush_pc;
      end
    end
  end

  assign flush  = flush_reg;
  assign new_pc = new_pc_reg;

  // Reset gates the vector directly: the stall inputs are combinational and
  // may still be active while the block is held in reset.
  always_comb begin
    stall = STALL_NONE;
    if (!rst || flush_reg) begin
      stall = STALL_NONE;
    end else if (stallreq_mem) begin
      stall = STALL_MEM;
    end else if (stallreq_ex || mc_stall) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end else if (stallreq_if) begin
      stall = STALL_IF;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_reg <= '0;
    end else if (stall[0] && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`else
  assign stall_cycles = ZERO_WORD;
`endif

endmodule
